// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and timing constants for the UART command controller
package uart_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CHK, COMMIT} state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 9600;
  // Two 10-bit character times of silence on the line.
  localparam int TIMEOUT_CYC_DEF = (CLK_FREQ * 20) / BAUD_RATE;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload byte buffer, synchronous write and combinational read at one index
module uart_cmd_buf
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [idx_w(MAX_LEN)-1:0]  idx_i,
  input  logic [7:0]                 wdata_i,
  output logic [7:0]                 rdata_o
);

  localparam int AW = idx_w(MAX_LEN);

  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - sync-hunting frame parser that commits checksummed register writes
// UART_CMD_CTRL_STATS_EN builds saturating good-frame and error counters.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int         TO_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        frame_ok,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        err_ovr,
  output logic [15:0] frames_cnt,
  output logic [15:0] errors_cnt
);

  localparam int              AW        = idx_w(MAX_LEN);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      base_q, base_d, len_q, len_d, idx_q, idx_d, xor_q, xor_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            frame_ok_q, frame_ok_d;
  logic            buf_we;
  logic [7:0]      buf_rdata;
  logic            last_idx;

  uart_cmd_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .idx_i   (idx_q[AW-1:0]),
    .wdata_i (rx_data),
    .rdata_o (buf_rdata)
  );

  assign last_idx = (idx_q == len_q - 8'd1);
  assign busy     = (state_q != IDLE);
  assign frame_ok = frame_ok_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      to_q       <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      to_q       <= to_d;
      frame_ok_q <= frame_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    to_d        = to_q;
    frame_ok_d  = 1'b0;
    buf_we      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    err_chk     = 1'b0;
    err_len     = 1'b0;
    err_timeout = 1'b0;
    err_ovr     = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout.
    if (state_q inside {ADDR, LEN, PAYLOAD, CHK}) begin
      if (rx_done) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        err_timeout = 1'b1;
        state_d     = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_d = ADDR;
          to_d    = '0;
          xor_d   = '0;
        end
      end
      ADDR: begin
        if (rx_done) begin
          base_d  = rx_data;
          xor_d   = rx_data;
          state_d = LEN;
        end
      end
      LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            err_len = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = rx_data;
            idx_d   = '0;
            xor_d   = xor_q ^ rx_data;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          buf_we = 1'b1;
          xor_d  = xor_q ^ rx_data;
          if (last_idx) begin
            idx_d   = '0;
            state_d = CHK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      CHK: begin
        if (rx_done) begin
          if (rx_data == xor_q) begin
            state_d = COMMIT;
          end else begin
            err_chk = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        wr_en   = 1'b1;
        wr_addr = base_q + idx_q;
        wr_data = buf_rdata;
        err_ovr = rx_done;
        if (wr_ready) begin
          if (last_idx) begin
            frame_ok_d = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_CMD_CTRL_STATS_EN
  logic [15:0] frames_q, errors_q;
  logic        err_any;

  assign err_any = err_chk | err_len | err_timeout | err_ovr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      if (frame_ok_q && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
      if (err_any && errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
    end
  end

  assign frames_cnt = frames_q;
  assign errors_cnt = errors_q;
`else
  assign frames_cnt = '0;
  assign errors_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized and directed bench for uart_cmd_ctrl against a frame-level model
module tb_uart_cmd_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 40;
  localparam int         TO_W    = 6;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        wr_ready = 1'b1;
  logic        wr_en, busy, frame_ok, err_chk, err_len, err_timeout, err_ovr;
  logic [7:0]  wr_addr, wr_data;
  logic [15:0] frames_cnt, errors_cnt;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_ovr(err_ovr),
    .frames_cnt(frames_cnt), .errors_cnt(errors_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;
  bit en    = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Frame-level model: mode 0 hunting, 1 collecting bytes after SYNC, 2 draining writes.
  int         mode = 0;
  logic [7:0] fq[$];
  int         last_cyc = 0;
  logic [7:0] wq_a[$], wq_d[$];
  bit         fok_pend = 0;
  int         exp_fc = 0, exp_ec = 0;

  // Logs of what the DUT actually did, used by the hand-computed checks.
  logic [7:0] wl_a[$], wl_d[$];
  int         wl_c[$];
  int         fok_n, chk_n, len_n, tmo_n, ovr_n, tmo_c, rx_c;

  always @(negedge clk) begin : compare
    logic       e_busy, e_wr, e_fok, e_chk, e_len, e_tmo, e_ovr;
    logic [7:0] e_a, e_d, xr;
    if (en) begin
      xr = 8'h00;
      foreach (fq[i]) xr = xr ^ fq[i];
      e_busy = (mode != 0);
      e_wr   = (mode == 2);
      e_a    = e_wr ? wq_a[0] : 8'h00;
      e_d    = e_wr ? wq_d[0] : 8'h00;
      e_fok  = fok_pend;
      e_tmo  = (mode == 1) && !rx_done && (ncyc - last_cyc == TMO);
      e_len  = (mode == 1) && rx_done && fq.size() == 1 && (rx_data == 8'd0 || rx_data > MAX_LEN);
      e_chk  = (mode == 1) && rx_done && fq.size() >= 2 && fq.size() == fq[1] + 2 && rx_data != xr;
      e_ovr  = (mode == 2) && rx_done;

      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr});
      chk("wr_addr", {24'd0, wr_addr}, {24'd0, e_a});
      chk("wr_data", {24'd0, wr_data}, {24'd0, e_d});
      chk("frame_ok", {31'd0, frame_ok}, {31'd0, e_fok});
      chk("err_chk", {31'd0, err_chk}, {31'd0, e_chk});
      chk("err_len", {31'd0, err_len}, {31'd0, e_len});
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, e_tmo});
      chk("err_ovr", {31'd0, err_ovr}, {31'd0, e_ovr});
`ifdef UART_CMD_CTRL_STATS_EN
      chk("frames_cnt", {16'd0, frames_cnt}, exp_fc);
      chk("errors_cnt", {16'd0, errors_cnt}, exp_ec);
`else
      chk("frames_cnt", {16'd0, frames_cnt}, 0);
      chk("errors_cnt", {16'd0, errors_cnt}, 0);
`endif

      if (wr_en && wr_ready) begin wl_a.push_back(wr_addr); wl_d.push_back(wr_data); wl_c.push_back(ncyc); end
      if (frame_ok) fok_n++;
      if (err_chk) chk_n++;
      if (err_len) len_n++;
      if (err_timeout) begin tmo_n++; tmo_c = ncyc; end
      if (err_ovr) ovr_n++;
      if (rx_done) rx_c = ncyc;

      if (!rst_n) begin
        mode = 0; fq.delete(); wq_a.delete(); wq_d.delete();
        fok_pend = 0; exp_fc = 0; exp_ec = 0;
      end else begin
        if (e_fok && exp_fc < 16'hFFFF) exp_fc++;
        if ((e_chk | e_len | e_tmo | e_ovr) && exp_ec < 16'hFFFF) exp_ec++;
        fok_pend = 0;
        case (mode)
          0: if (rx_done && rx_data == SYNC) begin mode = 1; fq.delete(); last_cyc = ncyc; end
          1: begin
            if (rx_done) begin
              last_cyc = ncyc;
              if (e_len || e_chk) begin
                mode = 0;
              end else begin
                fq.push_back(rx_data);
                if (fq.size() >= 3 && fq.size() == fq[1] + 3) begin
                  for (int i = 0; i < fq[1]; i++) begin
                    wq_a.push_back(fq[0] + 8'(i));
                    wq_d.push_back(fq[2 + i]);
                  end
                  mode = 2;
                end
              end
            end else if (e_tmo) begin
              mode = 0;
            end
          end
          default: if (wr_ready) begin
            void'(wq_a.pop_front()); void'(wq_d.pop_front());
            if (wq_a.size() == 0) begin mode = 0; fok_pend = 1; end
          end
        endcase
      end
    end
    ncyc++;
  end

  int rdy_mode = 0;
  int rdy_cnt  = 0;

  task automatic cyc(bit rx, logic [7:0] d);
    @(posedge clk); #1;
    rx_done = rx;
    rx_data = d;
    case (rdy_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = 1'($urandom_range(0, 1));
      default: begin wr_ready = (rdy_cnt % 6 == 5); rdy_cnt++; end
    endcase
  endtask

  task automatic send(logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 8'($urandom));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 300) begin idle(1); k++; end
    chk("wait_idle", {31'd0, busy}, 0);
  endtask

  function automatic int pick_gap();
    int r = int'($urandom % 40);
    if (r == 0) return TMO - 1;
    if (r == 1) return TMO;
    return int'($urandom % 3);
  endfunction

  task automatic send_q(logic [7:0] q[$], bit rgap);
    foreach (q[i]) begin
      send(q[i]);
      if (rgap) idle(pick_gap());
    end
  endtask

  task automatic clear_logs();
    wl_a.delete(); wl_d.delete(); wl_c.delete();
    fok_n = 0; chk_n = 0; len_n = 0; tmo_n = 0; ovr_n = 0;
  endtask

  logic [7:0] q[$];
  logic [7:0] x, addr;
  int kind, len;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc(1'b0, 8'h00);
    en = 1;
    rst_n = 1'b1;
    chk("reset_outs", {23'd0, busy, wr_en, wr_addr, frame_ok, err_chk, err_len, err_timeout, err_ovr}, 0);

    clear_logs();
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}, 0);
    wait_idle(); idle(2);
    chk("good_nwr", wl_a.size(), 3);
    chk("good_w0", {wl_a[0], wl_d[0]}, 16'h1011);
    chk("good_w1", {wl_a[1], wl_d[1]}, 16'h1122);
    chk("good_w2", {wl_a[2], wl_d[2]}, 16'h1233);
    chk("good_consec", wl_c[2] - wl_c[0], 2);
    chk("good_fok", fok_n, 1);
    chk("good_noerr", chk_n + len_n + tmo_n + ovr_n, 0);

    clear_logs();
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14}, 0);
    idle(3);
    chk("badchk_err", chk_n, 1);
    chk("badchk_nwr", wl_a.size(), 0);
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}, 0);
    wait_idle(); idle(2);
    chk("after_badchk_fok", fok_n, 1);

    clear_logs();
    send_q('{8'hA5, 8'h10, 8'h00, 8'h03, 8'h11, 8'hA5, 8'h10, 8'h11, 8'h01}, 0);
    idle(3);
    chk("badlen_err", len_n, 2);
    chk("badlen_idle", {31'd0, busy}, 0);

    clear_logs();
    send_q('{8'hA5, 8'h10}, 0);
    idle(TMO + 5);
    chk("tmo_count", tmo_n, 1);
    chk("tmo_delay", tmo_c - rx_c, TMO);
    clear_logs();
    send_q('{8'hA5, 8'h10}, 0);
    idle(TMO - 1);
    send(8'h03);
    idle(1);
    chk("tmo_suppressed", tmo_n, 0);
    idle(TMO + 5);
    chk("tmo_after_len", tmo_n, 1);

    clear_logs();
    rdy_mode = 2; rdy_cnt = 0;
    send_q('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC}, 0);
    wait_idle(); idle(2);
    chk("bp_nwr", wl_a.size(), 2);
    chk("bp_w0", {wl_a[0], wl_d[0]}, 16'hFFAA);
    chk("bp_w1", {wl_a[1], wl_d[1]}, 16'h00BB);
    chk("bp_spacing", wl_c[1] - wl_c[0], 6);
    chk("bp_fok", fok_n, 1);

    clear_logs();
    rdy_cnt = 0;
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}, 0);
    idle(3);
    send(8'h55);
    wait_idle(); idle(2);
    chk("ovr_err", ovr_n, 1);
    chk("ovr_nwr", wl_a.size(), 3);
    chk("ovr_fok", fok_n, 1);

    clear_logs();
    rdy_mode = 0;
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11}, 0);
    @(posedge clk); #1; rst_n = 1'b0; rx_done = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("rst_mid_outs", {23'd0, busy, wr_en, wr_addr, frame_ok, err_chk, err_len, err_timeout, err_ovr}, 0);
    chk("rst_mid_cnts", {frames_cnt, errors_cnt}, 0);
    send_q('{8'h22, 8'h33, 8'h13}, 0);
    idle(3);
    chk("rst_mid_nwr", wl_a.size(), 0);

    rdy_mode = 1;
    repeat (80) begin
      kind = int'($urandom % 6);
      addr = 8'($urandom);
      q.delete();
      q.push_back(SYNC);
      q.push_back(addr);
      if (kind == 4) len = ($urandom % 2) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      else len = int'($urandom_range(1, MAX_LEN));
      q.push_back(8'(len));
      if (kind != 4) begin
        x = addr ^ 8'(len);
        for (int i = 0; i < len; i++) begin
          q.push_back(8'($urandom));
          x = x ^ q[q.size() - 1];
        end
        if (kind == 3) x = x ^ (8'h01 << ($urandom % 8));
        q.push_back(x);
      end
      if (kind == 5) begin
        len = int'($urandom_range(1, q.size() - 2));
        while (q.size() > len + 1) void'(q.pop_back());
      end
      send_q(q, 1);
      if (kind == 5) idle(TMO + 2);
      if ($urandom % 2) wait_idle();
      else idle(int'($urandom % 4));
      if ($urandom % 8 == 0) send(8'($urandom));
    end
    wait_idle();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
